// File: rtl/aemb_icache_pkg.sv
// Shared types and helpers for the aeMB direct-mapped instruction cache.
package aemb_icache_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOOK  = 3'd1,
    FILL  = 3'd2,
    RESP  = 3'd3,
    FLUSH = 3'd4
  } state_e;

  // Tag width left over once the word offset and the index are removed.
  function automatic int tag_width(input int iw, input int aw);
    return iw - 2 - aw;
  endfunction

endpackage

// File: rtl/aemb_icache_ram.sv
// Tag and data arrays: one write port, one registered read port, no reset.
module aemb_icache_ram #(
  parameter int AW = 8,
  parameter int TW = 22
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wadr_i,
  input  logic [TW-1:0] wtag_i,
  input  logic [31:0]   wdat_i,
  input  logic          re_i,
  input  logic [AW-1:0] radr_i,
  output logic [TW-1:0] rtag_o,
  output logic [31:0]   rdat_o
);

  logic [TW-1:0] tag_mem [2**AW];
  logic [31:0]   dat_mem [2**AW];

  // Write on fill completion; read registered so the tag compare happens in LOOK.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_mem[wadr_i] <= wtag_i;
      dat_mem[wadr_i] <= wdat_i;
    end
    if (re_i) begin
      rtag_o <= tag_mem[radr_i];
      rdat_o <= dat_mem[radr_i];
    end
  end

endmodule

// File: rtl/aemb_icache.sv
// Direct-mapped, single-word-line instruction cache for the aeMB fetch port.
// Optional invalidate-all support is enabled with AEMB_ICACHE_FLUSH_EN.
module aemb_icache
  import aemb_icache_pkg::*;
#(
  parameter int IW = 32,
  parameter int AW = 8
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          iwb_stb_i,
  input  logic [IW-1:2] iwb_adr_i,
  output logic [31:0]   iwb_dat_o,
  output logic          iwb_ack_o,
  output logic          mem_stb_o,
  output logic [IW-1:2] mem_adr_o,
  input  logic [31:0]   mem_dat_i,
  input  logic          mem_ack_i
`ifdef AEMB_ICACHE_FLUSH_EN
  ,
  input  logic          ich_flush_i
`endif
);

  localparam int TW = tag_width(IW, AW);

  state_e          state_q, state_d;
  logic [IW-1:2]   adr_q, adr_d;
  logic            mem_stb_q, mem_stb_d;
  logic [IW-1:2]   mem_adr_q, mem_adr_d;
  logic [31:0]     fill_q, fill_d;
  logic            resp_ack_q, resp_ack_d;
  logic [2**AW-1:0] valid_q;

  logic            ram_re, ram_we;
  logic [TW-1:0]   ram_tag;
  logic [31:0]     ram_dat;
  logic [AW-1:0]   idx_q;
  logic [TW-1:0]   tag_q;
  logic            hit;
  logic            ack;
  logic [31:0]     dat;

  assign idx_q = adr_q[AW+1:2];
  assign tag_q = adr_q[IW-1:AW+2];
  assign hit   = valid_q[idx_q] && (ram_tag == tag_q);

`ifdef AEMB_ICACHE_FLUSH_EN
  localparam logic [AW-1:0] CNT_ONE = AW'(1);
  logic            flush_pend_q;
  logic [AW-1:0]   fcnt_q;
  logic            flush_req;
  assign flush_req = ich_flush_i || flush_pend_q;
`endif

  aemb_icache_ram #(.AW(AW), .TW(TW)) u_ram (
    .clk_i  (sys_clk_i),
    .we_i   (ram_we),
    .wadr_i (idx_q),
    .wtag_i (tag_q),
    .wdat_i (mem_dat_i),
    .re_i   (ram_re),
    .radr_i (iwb_adr_i[AW+1:2]),
    .rtag_o (ram_tag),
    .rdat_o (ram_dat)
  );

  // State register.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state, datapath updates and fetch-side outputs.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    mem_stb_d  = mem_stb_q;
    mem_adr_d  = mem_adr_q;
    fill_d     = fill_q;
    resp_ack_d = resp_ack_q;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    ack        = 1'b0;
    dat        = '0;
    case (state_q)
      IDLE: begin
`ifdef AEMB_ICACHE_FLUSH_EN
        if (flush_req) state_d = FLUSH;
        else
`endif
        if (iwb_stb_i) begin
          adr_d   = iwb_adr_i;
          ram_re  = 1'b1;
          state_d = LOOK;
        end
      end
      LOOK: begin
        if (!iwb_stb_i) begin
          state_d = IDLE;
        end else if (hit) begin
          ack     = 1'b1;
          dat     = ram_dat;
          state_d = IDLE;
        end else begin
          mem_stb_d  = 1'b1;
          mem_adr_d  = adr_q;
          resp_ack_d = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        // A withdrawn fetch still completes the fill; it only suppresses the ack.
        if (!iwb_stb_i) resp_ack_d = 1'b0;
        if (mem_ack_i) begin
          ram_we    = 1'b1;
          fill_d    = mem_dat_i;
          mem_stb_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        ack     = resp_ack_q;
        dat     = resp_ack_q ? fill_q : 32'd0;
        state_d = IDLE;
      end
`ifdef AEMB_ICACHE_FLUSH_EN
      FLUSH: begin
        if (fcnt_q == '1) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Address, memory strobe and fill registers.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      adr_q      <= '0;
      mem_stb_q  <= 1'b0;
      mem_adr_q  <= '0;
      fill_q     <= '0;
      resp_ack_q <= 1'b0;
    end else begin
      adr_q      <= adr_d;
      mem_stb_q  <= mem_stb_d;
      mem_adr_q  <= mem_adr_d;
      fill_q     <= fill_d;
      resp_ack_q <= resp_ack_d;
    end
  end

  // Valid bits: set on a completed fill, cleared by reset or a flush sweep.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      valid_q <= '0;
    end else begin
      if (ram_we) valid_q[idx_q] <= 1'b1;
`ifdef AEMB_ICACHE_FLUSH_EN
      if (state_q == FLUSH) valid_q[fcnt_q] <= 1'b0;
`endif
    end
  end

`ifdef AEMB_ICACHE_FLUSH_EN
  // Flush sweep counter and the pending flag for requests seen outside IDLE.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      fcnt_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      fcnt_q <= (state_q == FLUSH) ? fcnt_q + CNT_ONE : '0;
      if (state_q == IDLE)   flush_pend_q <= 1'b0;
      else if (ich_flush_i)  flush_pend_q <= 1'b1;
    end
  end
`endif

  assign iwb_ack_o = ack;
  assign iwb_dat_o = dat;
  assign mem_stb_o = mem_stb_q;
  assign mem_adr_o = mem_adr_q;

endmodule
